pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, fetch handshake,
// redirect handling and the IF/ID pipeline register.
module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fetch_req_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_done_i,
  input  logic [DATA_WIDTH-1:0] fetch_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  stall_i,
  output logic                  id_valid_o,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_instr_o
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  redirect_pend;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic [DATA_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0] hold_pc;

  logic [ADDR_WIDTH-1:0] rtgt;
  logic                  cap;
  logic [ADDR_WIDTH-1:0] cap_pc;
  logic [DATA_WIDTH-1:0] cap_instr;

  assign rtgt = redirect_pc_i & ~ADDR_WIDTH'(3);

  // Instruction offered to IF/ID this cycle, if stall and redirect allow.
  always_comb begin
    cap       = 1'b0;
    cap_pc    = pc;
    cap_instr = fetch_data_i;
    if (state == WAIT) begin
      cap = fetch_done_i && !redirect_pend;
    end else if (state == HOLD) begin
      cap       = 1'b1;
      cap_pc    = hold_pc;
      cap_instr = hold_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ISSUE;
      pc            <= RESET_PC;
      fetch_req_o   <= 1'b0;
      fetch_addr_o  <= '0;
      redirect_pend <= 1'b0;
      pend_pc       <= '0;
      hold_instr    <= '0;
      hold_pc       <= '0;
    end else begin
      unique case (state)
        ISSUE: begin
          if (redirect_i) begin
            pc <= rtgt;
          end else begin
            fetch_addr_o <= pc;
            fetch_req_o  <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (fetch_done_i) begin
            fetch_req_o   <= 1'b0;
            redirect_pend <= 1'b0;
            state         <= ISSUE;
            if (redirect_i) begin
              pc <= rtgt;
            end else if (redirect_pend) begin
              pc <= pend_pc;
            end else if (!stall_i) begin
              pc <= pc + ADDR_WIDTH'(4);
            end else begin
              hold_instr <= fetch_data_i;
              hold_pc    <= pc;
              state      <= HOLD;
            end
          end else if (redirect_i) begin
            redirect_pend <= 1'b1;
            pend_pc       <= rtgt;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc    <= rtgt;
            state <= ISSUE;
          end else if (!stall_i) begin
            pc    <= hold_pc + ADDR_WIDTH'(4);
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

  // IF/ID register: redirect flushes even through a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_o <= 1'b0;
      id_pc_o    <= '0;
      id_instr_o <= '0;
    end else if (redirect_i) begin
      id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (cap) begin
        id_valid_o <= 1'b1;
        id_pc_o    <= cap_pc;
        id_instr_o <= cap_instr;
      end else begin
        id_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level fetch model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_done_i = 1'b0;
  logic [31:0] fetch_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;

  int checks = 0;
  int failures = 0;

  pc_fetch_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h8000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req_o  (fetch_req_o),
    .fetch_addr_o (fetch_addr_o),
    .fetch_done_i (fetch_done_i),
    .fetch_data_i (fetch_data_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i      (stall_i),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_instr_o   (id_instr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cycle();
    checks++;
    if (fetch_req_o !== 1'b0 || fetch_addr_o !== 32'h0) begin
      $display("FAIL reset_fetch req=%0b addr=%h exp 0/0", fetch_req_o, fetch_addr_o);
      failures++;
    end
    checks++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_instr_o !== 32'h0) begin
      $display("FAIL reset_ifid v=%0b pc=%h i=%h exp 0", id_valid_o, id_pc_o, id_instr_o);
      failures++;
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0000) begin
      $display("FAIL first_fetch req=%0b addr=%h exp 1/80000000", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_basic();
    cycle();
    fetch_done_i = 1'b1;
    fetch_data_i = 32'h0000_0013;
    cycle();
    fetch_done_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'h8000_0000 || id_instr_o !== 32'h13) begin
      $display("FAIL basic_ifid v=%0b pc=%h i=%h exp 1/80000000/13", id_valid_o, id_pc_o, id_instr_o);
      failures++;
    end
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0004) begin
      $display("FAIL basic_next req=%0b addr=%h exp 1/80000004", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    d = $urandom;
    stall_i = 1'b1;
    cycle();
    fetch_done_i = 1'b1;
    fetch_data_i = d;
    cycle();
    fetch_done_i = 1'b0;
    repeat (2) cycle();
    checks++;
    if (fetch_req_o !== 1'b0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h8000_0000 ||
        id_instr_o !== 32'h13) begin
      $display("FAIL stall_hold req=%0b v=%0b pc=%h i=%h exp 0/0/80000000/13",
               fetch_req_o, id_valid_o, id_pc_o, id_instr_o);
      failures++;
    end
    stall_i = 1'b0;
    cycle();
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'h8000_0004 || id_instr_o !== d) begin
      $display("FAIL stall_release v=%0b pc=%h i=%h exp 1/80000004/%h", id_valid_o, id_pc_o, id_instr_o, d);
      failures++;
    end
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0008) begin
      $display("FAIL stall_next req=%0b addr=%h exp 1/80000008", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_redirect_wait();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0100;
    cycle();
    redirect_i = 1'b0;
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0008 || id_valid_o !== 1'b0) begin
      $display("FAIL redir_noabort req=%0b addr=%h v=%0b exp 1/80000008/0", fetch_req_o, fetch_addr_o, id_valid_o);
      failures++;
    end
    cycle();
    fetch_done_i = 1'b1;
    fetch_data_i = $urandom;
    cycle();
    fetch_done_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b0 || fetch_req_o !== 1'b0) begin
      $display("FAIL redir_discard v=%0b req=%0b exp 0/0", id_valid_o, fetch_req_o);
      failures++;
    end
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0100) begin
      $display("FAIL redir_target req=%0b addr=%h exp 1/80000100", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_redirect_stall();
    fetch_done_i = 1'b1;
    fetch_data_i = 32'hCAFE_0001;
    cycle();
    fetch_done_i = 1'b0;
    stall_i = 1'b1;
    cycle();
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'h8000_0100 || fetch_addr_o !== 32'h8000_0104) begin
      $display("FAIL rs_pre v=%0b pc=%h addr=%h exp 1/80000100/80000104", id_valid_o, id_pc_o, fetch_addr_o);
      failures++;
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0203;
    fetch_done_i = 1'b1;
    fetch_data_i = $urandom;
    cycle();
    redirect_i = 1'b0;
    fetch_done_i = 1'b0;
    stall_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b0 || fetch_req_o !== 1'b0 || id_pc_o !== 32'h8000_0100) begin
      $display("FAIL rs_flush v=%0b req=%0b pc=%h exp 0/0/80000100", id_valid_o, fetch_req_o, id_pc_o);
      failures++;
    end
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0200) begin
      $display("FAIL rs_align req=%0b addr=%h exp 1/80000200", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    fetch_done_i = 1'b1;
    cycle();
    redirect_i = 1'b0;
    fetch_done_i = 1'b0;
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_top req=%0b addr=%h exp 1/fffffffc", fetch_req_o, fetch_addr_o);
      failures++;
    end
    fetch_done_i = 1'b1;
    fetch_data_i = 32'h0000_0067;
    cycle();
    fetch_done_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'hFFFF_FFFC || id_instr_o !== 32'h67) begin
      $display("FAIL wrap_ifid v=%0b pc=%h i=%h exp 1/fffffffc/67", id_valid_o, id_pc_o, id_instr_o);
      failures++;
    end
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
      $display("FAIL wrap_zero req=%0b addr=%h exp 1/0", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_req_o !== 1'b0 || id_valid_o !== 1'b0) begin
      $display("FAIL async_reset req=%0b v=%0b exp 0/0", fetch_req_o, id_valid_o);
      failures++;
    end
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h8000_0000) begin
      $display("FAIL reset_refetch req=%0b addr=%h exp 1/80000000", fetch_req_o, fetch_addr_o);
      failures++;
    end
  endtask

  task automatic test_random();
    logic        m_valid, slot_v, redir_flag, killed, prev_req, prev_done;
    logic [31:0] m_pc, m_instr, slot_pc, slot_instr, last_tgt, cur_addr, exp_addr;
    int          wcnt;
    reset = 1'b1;
    fetch_done_i = 1'b0;
    redirect_i = 1'b0;
    stall_i = 1'b0;
    cycle();
    reset = 1'b0;
    m_valid = 1'b0; m_pc = '0; m_instr = '0;
    slot_v = 1'b0; slot_pc = '0; slot_instr = '0;
    redir_flag = 1'b1; last_tgt = 32'h8000_0000;
    killed = 1'b0; prev_req = 1'b0; prev_done = 1'b0;
    cur_addr = '0; wcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      checks++;
      if (id_valid_o !== m_valid || id_pc_o !== m_pc || id_instr_o !== m_instr) begin
        $display("FAIL rnd_ifid n=%0d got %0b/%h/%h exp %0b/%h/%h", n,
                 id_valid_o, id_pc_o, id_instr_o, m_valid, m_pc, m_instr);
        failures++;
      end
      if (fetch_req_o && !prev_req) begin
        exp_addr = redir_flag ? last_tgt : cur_addr + 32'd4;
        checks++;
        if (fetch_addr_o !== exp_addr) begin
          $display("FAIL rnd_addr n=%0d got %h exp %h", n, fetch_addr_o, exp_addr);
          failures++;
        end
        cur_addr = exp_addr;
        redir_flag = 1'b0;
        killed = 1'b0;
        wcnt = $urandom_range(0, 3);
      end else if (fetch_req_o) begin
        checks++;
        if (fetch_addr_o !== cur_addr) begin
          $display("FAIL rnd_stable n=%0d got %h exp %h", n, fetch_addr_o, cur_addr);
          failures++;
        end
      end
      if (!fetch_req_o && prev_req) begin
        checks++;
        if (prev_done !== 1'b1) begin
          $display("FAIL rnd_abort n=%0d req dropped, done=%0b exp 1", n, prev_done);
          failures++;
        end
      end
      if (fetch_done_i) begin
        fetch_done_i = 1'b0;
      end else if (fetch_req_o) begin
        if (wcnt == 0) begin
          fetch_done_i = 1'b1;
          fetch_data_i = $urandom;
        end else begin
          wcnt--;
        end
      end
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 9) == 0);
      redirect_pc_i = $urandom;
      prev_req = fetch_req_o;
      prev_done = fetch_done_i;
      if (redirect_i) begin
        redir_flag = 1'b1;
        last_tgt = redirect_pc_i & 32'hFFFF_FFFC;
        if (fetch_req_o) killed = 1'b1;
      end
      if (fetch_req_o && fetch_done_i && !killed) begin
        slot_v = 1'b1;
        slot_pc = cur_addr;
        slot_instr = fetch_data_i;
      end
      if (redirect_i) begin
        m_valid = 1'b0;
        slot_v = 1'b0;
      end else if (!stall_i) begin
        m_valid = slot_v;
        if (slot_v) begin
          m_pc = slot_pc;
          m_instr = slot_instr;
        end
        slot_v = 1'b0;
      end
      cycle();
    end
    fetch_done_i = 1'b0;
    redirect_i = 1'b0;
    stall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
